ws2812_stream_tx: RTL

WS2812_STREAM_TX -- requirements
Module: ws2812_stream_tx

---
 rtl/ws2812_stream_tx.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ws2812_stream_tx.sv
// WS2812 return-to-zero serialiser: streams BITS-wide pixel words MSB first,
// chaining up to N_LEDS pixels seamlessly, then holds the latch gap low.
module ws2812_stream_tx #(
   parameter int T_BIT   = 60,
   parameter int T0H     = 20,
   parameter int T1H     = 40,
   parameter int BITS    = 24,
   parameter int N_LEDS  = 8,
   parameter int T_RESET = 2500,
   parameter int INVERT  = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [BITS-1:0] s_data,
   input  logic            s_valid,
   output logic            s_ready,
   output logic            dout,
   output logic            busy,
   output logic            frame_done,
   output logic            underrun
);

   localparam int CNT_W = $clog2(T_BIT);
   localparam int BIT_W = (BITS > 1) ? $clog2(BITS) : 1;
   localparam int PIX_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
   localparam int LAT_W = (T_RESET > 1) ? $clog2(T_RESET) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T_BIT - 1);
   localparam logic [CNT_W-1:0] T0H_C    = CNT_W'(T0H);
   localparam logic [CNT_W-1:0] T1H_C    = CNT_W'(T1H);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS - 1);
   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(N_LEDS - 1);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(T_RESET - 1);
   localparam logic             INV_C    = (INVERT != 0) ? 1'b1 : 1'b0;

   generate
      if (!(T0H > 0 && T0H < T1H && T1H < T_BIT && T_RESET >= 1 && N_LEDS >= 1 && BITS >= 1))
      begin : g_bad_params
         $error("ws2812_stream_tx: illegal timing parameters");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, LATCH = 2'd2} state_t;

   state_t            state_r, nxt_state_s;
   logic [BITS-1:0]   shift_r, nxt_shift_s;
   logic [CNT_W-1:0]  cnt_r, nxt_cnt_s;
   logic [BIT_W-1:0]  bit_r, nxt_bit_s;
   logic [PIX_W-1:0]  pix_r, nxt_pix_s;
   logic [LAT_W-1:0]  lat_r, nxt_lat_s;
   logic              s_ready_r, dout_r, busy_r, frame_done_r, underrun_r;
   logic              accept_s, ready_s, line_s, frame_done_s, underrun_s;

   assign accept_s   = s_valid & s_ready_r;
   assign s_ready    = s_ready_r;
   assign dout       = dout_r;
   assign busy       = busy_r;
   assign frame_done = frame_done_r;
   assign underrun   = underrun_r;

   // Next-state decode; outputs are then registered from the next-state values
   always_comb begin
      nxt_state_s  = state_r;
      nxt_shift_s  = shift_r;
      nxt_cnt_s    = cnt_r;
      nxt_bit_s    = bit_r;
      nxt_pix_s    = pix_r;
      nxt_lat_s    = lat_r;
      frame_done_s = 1'b0;
      underrun_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               nxt_state_s = SEND;
               nxt_shift_s = s_data;
               nxt_cnt_s   = '0;
               nxt_bit_s   = '0;
               nxt_pix_s   = '0;
            end else begin
               nxt_state_s = IDLE;
            end
         end
         SEND: begin
            if (cnt_r != CNT_LAST) begin
               nxt_cnt_s = cnt_r + CNT_W'(1);
            end else if (bit_r != BIT_LAST) begin
               nxt_cnt_s   = '0;
               nxt_bit_s   = bit_r + BIT_W'(1);
               nxt_shift_s = shift_r << 1;
            end else if (accept_s) begin
               // seamless chaining: next pixel's first bit starts next cycle
               nxt_shift_s = s_data;
               nxt_cnt_s   = '0;
               nxt_bit_s   = '0;
               nxt_pix_s   = pix_r + PIX_W'(1);
            end else begin
               nxt_state_s = LATCH;
               nxt_cnt_s   = '0;
               nxt_bit_s   = '0;
               nxt_lat_s   = '0;
               underrun_s  = (pix_r != PIX_LAST);
            end
         end
         LATCH: begin
            if (lat_r == LAT_LAST) begin
               nxt_state_s  = IDLE;
               nxt_lat_s    = '0;
               frame_done_s = 1'b1;
            end else begin
               nxt_lat_s = lat_r + LAT_W'(1);
            end
         end
         default: begin
            nxt_state_s = IDLE;
         end
      endcase
      ready_s = (nxt_state_s == IDLE) ||
                ((nxt_state_s == SEND) && (nxt_cnt_s == CNT_LAST) &&
                 (nxt_bit_s == BIT_LAST) && (nxt_pix_s < PIX_LAST));
      line_s  = (nxt_state_s == SEND) &&
                (nxt_shift_s[BITS-1] ? (nxt_cnt_s < T1H_C) : (nxt_cnt_s < T0H_C));
   end

   // State, counters and registered outputs with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         shift_r      <= '0;
         cnt_r        <= '0;
         bit_r        <= '0;
         pix_r        <= '0;
         lat_r        <= '0;
         s_ready_r    <= 1'b0;
         dout_r       <= INV_C;
         busy_r       <= 1'b0;
         frame_done_r <= 1'b0;
         underrun_r   <= 1'b0;
      end else begin
         state_r      <= nxt_state_s;
         shift_r      <= nxt_shift_s;
         cnt_r        <= nxt_cnt_s;
         bit_r        <= nxt_bit_s;
         pix_r        <= nxt_pix_s;
         lat_r        <= nxt_lat_s;
         s_ready_r    <= ready_s;
         dout_r       <= line_s ^ INV_C;
         busy_r       <= (nxt_state_s != IDLE);
         frame_done_r <= frame_done_s;
         underrun_r   <= underrun_s;
      end
   end

endmodule
